// File: rtl/jtdd_rom_pkg.sv
// Shared constants and FSM encoding for the ROM fetch arbiter.
package jtdd_rom_pkg;

   localparam int SLOTS_DEF = 4;
   localparam int AW_DEF    = 22;
   localparam int DW        = 32;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_ACK  = 2'd1,
      ST_WAIT_DATA = 2'd2
   } arb_st_e;

endpackage

// File: rtl/jtdd_rom_slot.sv
// One-entry read cache for a single requester.
// The hit compare is combinational, so a cached address is served in the same cycle.
module jtdd_rom_slot
   import jtdd_rom_pkg::*;
#(
   parameter int AW = AW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr_i,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_tag_i,
   input  logic [DW-1:0] wr_data_i,
   input  logic          cs_i,
   input  logic [AW-1:0] addr_i,
   output logic          ok_o,
   output logic [DW-1:0] dout_o
);

   logic [AW-1:0] tag_q;
   logic [DW-1:0] data_q;
   logic          valid_q;

   // A download only invalidates; stale data stays visible on dout_o.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else if (clr_i) begin
         valid_q <= 1'b0;
      end else if (wr_en_i) begin
         tag_q   <= wr_tag_i;
         data_q  <= wr_data_i;
         valid_q <= 1'b1;
      end
   end

   assign ok_o   = cs_i & valid_q & (tag_q == addr_i);
   assign dout_o = data_q;

endmodule

// File: rtl/jtdd_rom_arb.sv
// Round-robin SDRAM read arbiter feeding per-slot one-entry caches.
// Grants one missing slot at a time; the fill always uses the address captured at grant.
module jtdd_rom_arb
   import jtdd_rom_pkg::*;
#(
   parameter int            SLOTS   = SLOTS_DEF,
   parameter int            AW      = AW_DEF,
   parameter logic [AW-1:0] OFFSET0 = 22'h0,
   parameter logic [AW-1:0] OFFSET1 = 22'h0,
   parameter logic [AW-1:0] OFFSET2 = 22'h0,
   parameter logic [AW-1:0] OFFSET3 = 22'h0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                downloading,
   input  logic [SLOTS-1:0]    slot_cs,
   input  logic [SLOTS*AW-1:0] slot_addr,
   output logic [SLOTS-1:0]    slot_ok,
   output logic [SLOTS*DW-1:0] slot_dout,
   output logic                sdram_req,
   output logic [AW-1:0]       sdram_addr,
   input  logic                sdram_ack,
   input  logic                data_rdy,
   input  logic [DW-1:0]       data_read,
   output logic                refresh_en,
   output logic                ready
);

   localparam int GW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

   arb_st_e       st_q;
   logic [GW-1:0] last_q;
   logic [AW-1:0] gaddr_q;
   logic          req_q;
   logic [AW-1:0] saddr_q;
   logic          refresh_q;

   logic [AW-1:0]    addr_a [SLOTS];
   logic [SLOTS-1:0] pending;
   logic [SLOTS-1:0] wr_en;
   logic             gnt_found;
   logic [GW-1:0]    gnt_sel;

   function automatic logic [AW-1:0] slot_off(input logic [GW-1:0] s);
      case (int'(s))
         0:       slot_off = OFFSET0;
         1:       slot_off = OFFSET1;
         2:       slot_off = OFFSET2;
         3:       slot_off = OFFSET3;
         default: slot_off = '0;
      endcase
   endfunction

   genvar i;
   generate
      for (i = 0; i < SLOTS; i++) begin : g_slot
         assign addr_a[i] = slot_addr[i*AW +: AW];
         assign wr_en[i]  = (st_q == ST_WAIT_DATA) && data_rdy && !downloading
                            && (last_q == GW'(i));

         jtdd_rom_slot #(.AW(AW)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr_i     (downloading),
            .wr_en_i   (wr_en[i]),
            .wr_tag_i  (gaddr_q),
            .wr_data_i (data_read),
            .cs_i      (slot_cs[i]),
            .addr_i    (addr_a[i]),
            .ok_o      (slot_ok[i]),
            .dout_o    (slot_dout[i*DW +: DW])
         );
      end
   endgenerate

   assign pending = slot_cs & ~slot_ok;

   // Search starts just past the last winner, so every requester is reached within SLOTS grants.
   always_comb begin
      int idx;
      gnt_found = 1'b0;
      gnt_sel   = last_q;
      for (int k = 1; k <= SLOTS; k++) begin
         idx = (int'(last_q) + k) % SLOTS;
         if (!gnt_found && pending[idx]) begin
            gnt_found = 1'b1;
            gnt_sel   = GW'(idx);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q      <= ST_IDLE;
         last_q    <= GW'(SLOTS-1);
         gaddr_q   <= '0;
         req_q     <= 1'b0;
         saddr_q   <= '0;
         refresh_q <= 1'b1;
      end else if (downloading) begin
         st_q      <= ST_IDLE;
         req_q     <= 1'b0;
         refresh_q <= 1'b1;
      end else begin
         case (st_q)
            ST_IDLE: begin
               if (gnt_found) begin
                  st_q      <= ST_WAIT_ACK;
                  last_q    <= gnt_sel;
                  gaddr_q   <= addr_a[gnt_sel];
                  req_q     <= 1'b1;
                  saddr_q   <= addr_a[gnt_sel] + slot_off(gnt_sel);
                  refresh_q <= 1'b0;
               end else begin
                  refresh_q <= 1'b1;
               end
            end
            // A data_rdy alongside the ack belongs to nothing yet and is dropped.
            ST_WAIT_ACK: begin
               if (sdram_ack) begin
                  st_q  <= ST_WAIT_DATA;
                  req_q <= 1'b0;
               end
            end
            ST_WAIT_DATA: begin
               if (data_rdy) st_q <= ST_IDLE;
            end
            default: begin
               st_q  <= ST_IDLE;
               req_q <= 1'b0;
            end
         endcase
      end
   end

   assign sdram_req  = req_q;
   assign sdram_addr = saddr_q;
   assign refresh_en = refresh_q;
   assign ready      = ~downloading;

endmodule

// File: tb/tb_jtdd_rom_arb.sv
// Directed bench for jtdd_rom_arb: miss/hit, round-robin, address change, download abort, reset.
module tb_jtdd_rom_arb;

   localparam int SLOTS = 4;
   localparam int AW    = 22;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                downloading;
   logic [SLOTS-1:0]    slot_cs;
   logic [SLOTS*AW-1:0] slot_addr;
   logic [SLOTS-1:0]    slot_ok;
   logic [SLOTS*32-1:0] slot_dout;
   logic                sdram_req;
   logic [AW-1:0]       sdram_addr;
   logic                sdram_ack;
   logic                data_rdy;
   logic [31:0]         data_read;
   logic                refresh_en;
   logic                ready;

   int n_chk = 0;
   int n_err = 0;

   jtdd_rom_arb #(
      .SLOTS(SLOTS), .AW(AW),
      .OFFSET0(22'h0), .OFFSET1(22'h20000), .OFFSET2(22'h30000), .OFFSET3(22'h300000)
   ) dut (
      .clk(clk), .rst_n(rst_n), .downloading(downloading),
      .slot_cs(slot_cs), .slot_addr(slot_addr), .slot_ok(slot_ok), .slot_dout(slot_dout),
      .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
      .data_rdy(data_rdy), .data_read(data_read), .refresh_en(refresh_en), .ready(ready)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_req(input int max);
      int n = 0;
      while (sdram_req !== 1'b1 && n < max) begin
         tick();
         n++;
      end
      chk("req_seen", sdram_req, 1);
   endtask

   task automatic serve(input string tag, input logic [AW-1:0] exp_addr, input logic [31:0] d);
      wait_req(6);
      chk(tag, sdram_addr, exp_addr);
      sdram_ack = 1'b1;
      tick();
      sdram_ack = 1'b0;
      chk("req_drop", sdram_req, 0);
      data_rdy  = 1'b1;
      data_read = d;
      tick();
      data_rdy  = 1'b0;
   endtask

   logic [AW-1:0] rr_addr [4];
   logic [31:0]   rr_data [4];

   initial begin
      rst_n = 1'b0; downloading = 1'b0; slot_cs = '0; slot_addr = '0;
      sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0;
      repeat (3) tick();
      // reset state
      chk("rst_req", sdram_req, 0);
      chk("rst_addr", sdram_addr, 0);
      chk("rst_refresh", refresh_en, 1);
      chk("rst_ok", slot_ok, 0);
      chk("rst_dout", slot_dout, 0);
      chk("rst_ready", ready, 1);
      rst_n = 1'b1;
      tick();

      // single miss with stray data_rdy in WAIT_ACK, then ack+data_rdy together
      slot_addr[1*AW +: AW] = 22'h100;
      slot_cs = 4'b0010;
      #1 chk("miss_ok0", slot_ok[1], 0);
      tick();
      chk("miss_req", sdram_req, 1);
      chk("miss_addr", sdram_addr, 22'h20100);
      chk("miss_refresh", refresh_en, 0);
      data_rdy = 1'b1; data_read = 32'h11111111;
      tick();
      data_rdy = 1'b0;
      chk("ack_wait_rdy_ignored", slot_ok[1], 0);
      chk("ack_wait_req", sdram_req, 1);
      tick();
      tick();
      sdram_ack = 1'b1; data_rdy = 1'b1; data_read = 32'h22222222;
      tick();
      sdram_ack = 1'b0; data_rdy = 1'b0;
      chk("ack_req_drop", sdram_req, 0);
      chk("ack_plus_rdy_no_fill", slot_ok[1], 0);
      data_rdy = 1'b1; data_read = 32'hDEADBEEF;
      tick();
      data_rdy = 1'b0;
      chk("fill_ok", slot_ok[1], 1);
      chk("fill_dout", slot_dout[1*32 +: 32], 32'hDEADBEEF);
      tick();
      chk("idle_refresh", refresh_en, 1);

      // hit
      tick();
      chk("hit_ok", slot_ok[1], 1);
      chk("hit_no_req", sdram_req, 0);
      slot_cs = 4'b0000;
      #1 chk("no_cs_no_ok", slot_ok[1], 0);

      // round-robin from reset
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("rst_clears_data", slot_dout[1*32 +: 32], 0);
      rr_addr = '{22'h10, 22'h20200, 22'h30300, 22'h0F0000};
      rr_data = '{32'hA0000000, 32'hA0000001, 32'hA0000002, 32'hA0000003};
      slot_addr[0*AW +: AW] = 22'h10;
      slot_addr[1*AW +: AW] = 22'h200;
      slot_addr[2*AW +: AW] = 22'h300;
      slot_addr[3*AW +: AW] = 22'h1F0000;
      slot_cs = 4'b1111;
      for (int i = 0; i < 4; i++) serve($sformatf("rr_addr%0d", i), rr_addr[i], rr_data[i]);
      chk("rr_all_ok", slot_ok, 4'hF);
      chk("rr_dout3", slot_dout[3*32 +: 32], 32'hA0000003);
      slot_addr[0*AW +: AW] = 22'h11;
      slot_addr[2*AW +: AW] = 22'h301;
      serve("rr2_first", 22'h11, 32'hB0000000);
      serve("rr2_second", 22'h30301, 32'hB0000002);
      chk("rr2_all_ok", slot_ok, 4'hF);

      // address change after grant
      slot_cs = 4'b0100;
      slot_addr[2*AW +: AW] = 22'h40;
      wait_req(6);
      chk("chg_addr", sdram_addr, 22'h30040);
      sdram_ack = 1'b1;
      tick();
      sdram_ack = 1'b0;
      slot_addr[2*AW +: AW] = 22'h41;
      data_rdy = 1'b1; data_read = 32'hCAFE0040;
      tick();
      data_rdy = 1'b0;
      chk("chg_ok_low", slot_ok[2], 0);
      slot_addr[2*AW +: AW] = 22'h40;
      #1 chk("chg_tag_old", slot_ok[2], 1);
      chk("chg_dout", slot_dout[2*32 +: 32], 32'hCAFE0040);
      slot_addr[2*AW +: AW] = 22'h41;
      #1 serve("chg_refetch", 22'h30041, 32'hCAFE0041);
      chk("chg_refill_ok", slot_ok[2], 1);

      // download abort during WAIT_DATA
      slot_cs = 4'b1000;
      slot_addr[3*AW +: AW] = 22'h1F0001;
      wait_req(6);
      chk("trunc_addr", sdram_addr, 22'h0F0001);
      sdram_ack = 1'b1;
      tick();
      sdram_ack = 1'b0;
      slot_cs = 4'b1111;
      downloading = 1'b1;
      #1 chk("dl_ready", ready, 0);
      tick();
      chk("dl_req", sdram_req, 0);
      chk("dl_ok", slot_ok, 0);
      chk("dl_refresh", refresh_en, 1);
      data_rdy = 1'b1; data_read = 32'h99999999;
      tick();
      data_rdy = 1'b0;
      tick();
      chk("dl_no_grant", sdram_req, 0);
      downloading = 1'b0;
      slot_cs = 4'b0000;
      #1 chk("dl_no_write", slot_dout[3*32 +: 32], 32'hA0000003);
      chk("dl_ready_back", ready, 1);

      // reset during WAIT_ACK
      tick();
      slot_addr[0*AW +: AW] = 22'h55;
      slot_cs = 4'b0001;
      wait_req(6);
      chk("pre_rst_addr", sdram_addr, 22'h55);
      #1 rst_n = 1'b0;
      #1 chk("async_req", sdram_req, 0);
      chk("async_refresh", refresh_en, 1);
      chk("async_ok", slot_ok, 0);
      slot_cs = 4'b0011;
      slot_addr[1*AW +: AW] = 22'h200;
      #2 rst_n = 1'b1;
      serve("post_rst_slot0", 22'h55, 32'h55555555);
      chk("post_rst_ok0", slot_ok[0], 1);
      serve("post_rst_slot1", 22'h20200, 32'h66666666);
      chk("post_rst_ok", slot_ok[1:0], 2'b11);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/jtdd_rom_arb.md
JTDD_ROM_ARB -- requirements
Module: jtdd_rom_arb

Interface
REQ-001 SHALL have these parameters:
- SLOTS, 4, number of requesters.
- AW, 22, SDRAM word address width.
- OFFSET0..OFFSET3, 22'h0, per-slot word offsets added to the slot address.
REQ-002 SHALL have these ports, one per line:
- clk  in  1  system clock (48 MHz).
- rst_n  in  1  asynchronous active-low reset.
- downloading  in  1  ROM load in progress.
- slot_cs  in  SLOTS  per-slot fetch request.
- slot_addr  in  SLOTS*AW  per-slot word address; slot i occupies bits [i*AW +: AW].
- slot_ok  out  SLOTS  slot data valid for the current slot_addr.
- slot_dout  out  SLOTS*32  per-slot cached data; slot i occupies bits [i*32 +: 32].
- sdram_req  out  1  SDRAM read request.
- sdram_addr  out  AW  SDRAM word address.
- sdram_ack  in  1  SDRAM accepted the request.
- data_rdy  in  1  data_read is valid.
- data_read  in  32  SDRAM read data.
- refresh_en  out  1  SDRAM may refresh.
- ready  out  1  arbiter operational; equals ~downloading.
REQ-003 Clock and reset SHALL be one clock, clk; reset SHALL be asynchronous and active-low, rst_n.

Function
REQ-004 Each slot SHALL hold a one-entry cache: tag (AW bits), data (32 bits) and valid (1 bit).
REQ-005 slot_ok[i] SHALL equal slot_cs[i] AND valid[i] AND (tag[i]==slot_addr[i]), combinationally (zero-cycle hit).
REQ-006 slot_dout[i] SHALL always present data[i].
REQ-007 A slot SHALL be "pending" when slot_cs=1 and slot_ok=0.
REQ-008 The FSM SHALL have exactly three states: IDLE, WAIT_ACK and WAIT_DATA.
REQ-009 In IDLE with downloading=0 and any slot pending, the block SHALL grant one slot by round-robin starting from (last_grant+1) mod SLOTS, capture that slot's address into a grant register, and enter WAIT_ACK on the next clock.
REQ-010 In WAIT_ACK, sdram_req SHALL be 1 and sdram_addr SHALL equal the captured address + OFFSETn, truncated to AW bits.
REQ-011 On sdram_ack=1 in WAIT_ACK, sdram_req SHALL drop on the next clock and the FSM SHALL enter WAIT_DATA.
REQ-012 In WAIT_DATA, on data_rdy=1 the block SHALL write tag=captured address, data=data_read and valid=1 for the granted slot, then return to IDLE.
- The granted slot's slot_ok therefore rises one cycle after data_rdy if its address is unchanged.
REQ-013 If slot_addr changes after grant, the fill SHALL still use the captured address; the slot stays pending and is re-arbitrated later.
REQ-014 data_rdy in IDLE or WAIT_ACK SHALL be ignored.
REQ-015 ack and data_rdy asserted in the same cycle in WAIT_ACK SHALL be treated as ack only.
REQ-016 last_grant SHALL update only on grant, so no pending slot waits more than SLOTS-1 transactions.
REQ-017 downloading=1 SHALL, on the next clock:
- clear every valid bit;
- force the FSM to IDLE;
- drive sdram_req=0;
- discard any in-flight data.
No grants SHALL occur while downloading=1.
REQ-018 refresh_en SHALL be 1 only in IDLE with no slot pending, or while downloading=1.
REQ-019 sdram_req, sdram_addr and refresh_en SHALL be registered outputs.

Reset
REQ-020 While rst_n=0, the block SHALL hold:
- FSM in IDLE;
- sdram_req=0 and sdram_addr=0;
- all valid, tag and data registers at 0;
- last_grant=SLOTS-1, so that slot 0 wins first;
- refresh_en=1.
REQ-021 A reset mid-transaction SHALL abandon the transaction with no cache write.

Structure
REQ-022 The state encoding and the default SLOTS/AW constants SHALL live in a shared package, jtdd_rom_pkg.
REQ-023 The per-slot cache and hit compare SHALL be one sub-module, jtdd_rom_slot, instantiated SLOTS times with a generate loop.
REQ-024 The FSM and the round-robin pointer SHALL remain in the top level.

Verification
REQ-025 Single miss: slot1 cs=1, addr=22'h100, OFFSET1=22'h20000.
- Required: sdram_req=1, sdram_addr=22'h20100.
- Ack after 3 cycles, then data_rdy with data_read=32'hDEADBEEF.
- Then slot_ok[1]=1 and slot_dout[1]=32'hDEADBEEF the next cycle.
REQ-026 Hit: repeat the slot1 request for addr 22'h100.
- Required: slot_ok[1]=1 the same cycle, with no sdram_req.
REQ-027 Round-robin: all four slots miss at once from reset.
- Required: grants in order 0,1,2,3.
- Then slot0 and slot2 miss again: order 0,2.
REQ-028 Address change: slot2 granted with addr 22'h40, which changes to 22'h41 before data_rdy.
- Required: tag=22'h40 and slot_ok[2]=0.
- A new request follows for 22'h41.
REQ-029 Download abort: downloading=1 during WAIT_DATA.
- Required: sdram_req=0, all slot_ok=0, ready=0, refresh_en=1.
- A subsequent data_rdy causes no cache write.
REQ-030 Reset during WAIT_ACK: pulse rst_n low.
- Required: sdram_req=0 immediately (asynchronously).
- After release, slot0 is granted first.
